// File: rtl/simon_3264.sv
// simon_3264: iterative SIMON 32/64 encrypt/decrypt core with on-chip key expansion
module simon_3264 #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int Co = 5
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [1:0][N-1:0]   inData,
  input  logic [M-1:0][N-1:0] key,
  output logic                loadData,
  output logic                loadKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [1:0][N-1:0]   outData,
  output logic [3:0]          mode
);
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    KEYEXP = 4'd1,
    READY  = 4'd2,
    ROUNDS = 4'd3,
    DONE   = 4'd4
  } state_t;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction
  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return rol(v, N - s);
  endfunction
  state_t         state;
  logic [N-1:0]   rk [T];
  logic [N-1:0]   x, y, t0, t1, new_rk, new_x;
  logic [Co-1:0]  cnt;
  logic [5:0]     zi;
  logic           enc, fin, data_arm, key_arm, key_go, data_go;
  assign mode = state;
  // request arbitration, key-schedule step and round step
  always_comb begin
    key_go  = (state == IDLE || state == READY) && newKey && key_arm;
    data_go = state == READY && newData && data_arm && !key_go;
    zi      = 6'd61 - 6'(cnt);
    t0      = ror(rk[cnt + Co'(3)], 3) ^ rk[cnt + Co'(1)];
    t1      = t0 ^ ror(t0, 1);
    new_rk  = ~rk[cnt] ^ t1 ^ {{(N-1){1'b0}}, Z0[zi]} ^ N'(3);
    new_x   = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ rk[enc ? cnt : ~cnt];
  end
  // control FSM, key store and datapath; decryption swaps halves and walks keys backwards
  always_ff @(posedge clk) begin
    if (!nR) begin
      state    <= IDLE;
      loadData <= 1'b0;
      loadKey  <= 1'b0;
      doneData <= 1'b0;
      doneKey  <= 1'b0;
      outData  <= '0;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      enc      <= 1'b0;
      fin      <= 1'b0;
      data_arm <= 1'b1;
      key_arm  <= 1'b1;
    end else begin
      loadData <= data_go;
      loadKey  <= key_go;
      data_arm <= !newData || (data_arm && !data_go);
      key_arm  <= !newKey || (key_arm && !key_go);
      if (key_go) begin
        for (int j = 0; j < M; j++) rk[j] <= key[j];
        doneKey <= 1'b0;
        cnt     <= '0;
        state   <= KEYEXP;
      end else if (data_go) begin
        {x, y} <= enc_dec ? inData : {inData[0], inData[1]};
        enc    <= enc_dec;
        cnt    <= '0;
        fin    <= 1'b0;
        state  <= ROUNDS;
      end else begin
        case (state)
          KEYEXP: begin
            rk[cnt + Co'(4)] <= new_rk;
            cnt              <= cnt + Co'(1);
            if (cnt == Co'(T - 5)) begin
              doneKey <= 1'b1;
              state   <= READY;
            end
          end
          ROUNDS: begin
            if (fin) begin
              outData  <= enc ? {x, y} : {y, x};
              doneData <= 1'b1;
              state    <= DONE;
            end else begin
              x   <= new_x;
              y   <= x;
              cnt <= cnt + Co'(1);
              fin <= cnt == Co'(T - 1);
            end
          end
          DONE: begin
            if (readData) begin
              doneData <= 1'b0;
              state    <= READY;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_simon_3264.sv
// tb_simon_3264: directed and randomized checks of simon_3264 against a behavioural SIMON model
module tb_simon_3264;
  logic              clk = 1'b0;
  logic              nR = 1'b0, newData = 1'b0, newKey = 1'b0, enc_dec = 1'b0, readData = 1'b0;
  logic [1:0][15:0]  inData = '0;
  logic [3:0][15:0]  key = '0;
  logic              loadData, loadKey, doneData, doneKey;
  logic [1:0][15:0]  outData;
  logic [3:0]        mode;
  int                checks = 0, errors = 0, n_ld = 0;
  logic [15:0]       ks [32];
  logic [61:0]       z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  logic [31:0]       pt [5] = '{32'hA8D5F7DE, 32'h5BC92D01, 32'hF2B48D45, 32'h567F11DE, 32'h65656877};
  logic [31:0]       ct [5];

  simon_3264 dut (
    .clk(clk), .nR(nR), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
    .readData(readData), .inData(inData), .key(key), .loadData(loadData),
    .loadKey(loadKey), .doneData(doneData), .doneKey(doneKey), .outData(outData), .mode(mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (loadData) n_ld++;

  function automatic logic [15:0] rl(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction
  function automatic logic [15:0] rr(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction
  function automatic void expand(input logic [63:0] kv);
    logic [15:0] tmp;
    for (int i = 0; i < 4; i++) ks[i] = kv[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp = rr(ks[i-1], 3) ^ ks[i-3];
      tmp = tmp ^ rr(tmp, 1);
      ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, z0[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
  endfunction
  function automatic logic [31:0] enc_m(input logic [31:0] p);
    logic [15:0] a, b, t;
    a = p[31:16];
    b = p[15:0];
    for (int i = 0; i < 32; i++) begin
      t = a;
      a = b ^ ((rl(a, 1) & rl(a, 8)) ^ rl(a, 2)) ^ ks[i];
      b = t;
    end
    return {a, b};
  endfunction
  function automatic logic sig(input int w);
    return w == 0 ? loadKey : w == 1 ? doneKey : w == 2 ? loadData : doneData;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_on(input int w, input string tag, output int n);
    n = 0;
    while (!sig(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in time"}, 32'(n < 200), 32'd1);
  endtask
  task automatic do_reset();
    nR = 1'b0;
    newKey = 1'b0;
    newData = 1'b0;
    readData = 1'b0;
    repeat (2) @(negedge clk);
    nR = 1'b1;
  endtask
  task automatic load_key(input logic [63:0] kv);
    int n;
    key = kv;
    expand(kv);
    newKey = 1'b1;
    wait_on(0, "loadKey", n);
    newKey = 1'b0;
    wait_on(1, "doneKey", n);
    chk("key expansion latency", n, 28);
  endtask
  task automatic read_out();
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    chk("doneData cleared by read", doneData, 0);
  endtask
  task automatic stream(input bit e);
    int n, base;
    logic [31:0] held;
    base = n_ld;
    inData = e ? pt[0] : ct[0];
    enc_dec = e;
    newData = 1'b1;
    for (int b = 0; b < 5; b++) begin
      wait_on(2, "stream load", n);
      newData = 1'b0;
      if (b > 0) chk("load one cycle after read", n, 1);
      wait_on(3, "stream done", n);
      chk("stream latency", n, 33);
      chk(e ? "stream encrypt" : "stream decrypt", outData, e ? ct[b] : pt[b]);
      held = outData;
      if (b < 4) begin
        inData = e ? pt[b+1] : ct[b+1];
        newData = 1'b1;
      end
      repeat (3) begin
        @(negedge clk);
        chk("outData stable until read", outData, held);
        chk("no load while DONE", loadData, 0);
      end
      read_out();
    end
    repeat (3) @(negedge clk);
    chk("stream load count", n_ld - base, 5);
  endtask

  initial begin
    int n, base;
    logic [63:0] kr, k2;
    logic [31:0] r;
    repeat (2) @(negedge clk);
    chk("reset mode", mode, 0);
    chk("reset outData", outData, 0);
    chk("reset flags", {loadData, loadKey, doneData, doneKey}, 0);
    // known encryption vector with key and data requested together
    key = 64'h1918111009080100;
    inData = 32'h65656877;
    enc_dec = 1'b1;
    newKey = 1'b1;
    newData = 1'b1;
    nR = 1'b1;
    wait_on(0, "vec loadKey", n);
    chk("key before data", loadData, 0);
    wait_on(1, "vec doneKey", n);
    chk("vec expansion latency", n, 28);
    wait_on(2, "vec loadData", n);
    chk("vec load after doneKey", n, 1);
    newData = 1'b0;
    newKey = 1'b0;
    wait_on(3, "vec doneData", n);
    chk("vec latency", n, 33);
    chk("vec ciphertext", outData, 32'hC69BE9BB);
    read_out();
    // known decryption vector
    do_reset();
    chk("doneKey after reset", doneKey, 0);
    inData = 32'hC69BE9BB;
    enc_dec = 1'b0;
    newData = 1'b1;
    load_key(64'h1918111009080100);
    wait_on(2, "dec loadData", n);
    newData = 1'b0;
    wait_on(3, "dec doneData", n);
    chk("dec plaintext", outData, 32'h65656877);
    read_out();
    // five-block stream under a random key, then decrypt after reset
    kr = {$urandom, $urandom};
    do_reset();
    load_key(kr);
    for (int b = 0; b < 5; b++) ct[b] = enc_m(pt[b]);
    stream(1'b1);
    do_reset();
    load_key(kr);
    stream(1'b0);
    // held newData must not start a second block
    r = $urandom;
    base = n_ld;
    inData = r;
    enc_dec = 1'b1;
    newData = 1'b1;
    wait_on(2, "arm load", n);
    wait_on(3, "arm done", n);
    chk("arm encrypt", outData, enc_m(r));
    read_out();
    repeat (40) @(negedge clk);
    chk("held newData single load", n_ld - base, 1);
    chk("held newData stays READY", mode, 2);
    newData = 1'b0;
    @(negedge clk);
    r = $urandom;
    inData = r;
    newData = 1'b1;
    wait_on(2, "rearm load", n);
    newData = 1'b0;
    wait_on(3, "rearm done", n);
    chk("rearm encrypt", outData, enc_m(r));
    read_out();
    // key and data together while READY: key wins
    k2 = {$urandom, $urandom};
    expand(k2);
    key = k2;
    r = $urandom;
    inData = r;
    newKey = 1'b1;
    newData = 1'b1;
    wait_on(0, "prio loadKey", n);
    chk("prio no data load", loadData, 0);
    newKey = 1'b0;
    wait_on(1, "prio doneKey", n);
    chk("prio expansion latency", n, 28);
    wait_on(2, "prio loadData", n);
    chk("prio data after key", n, 1);
    newData = 1'b0;
    wait_on(3, "prio done", n);
    chk("prio encrypt new key", outData, enc_m(r));
    read_out();
    // reset in the middle of ROUNDS
    inData = $urandom;
    newData = 1'b1;
    wait_on(2, "abort load", n);
    newData = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort in ROUNDS", mode, 3);
    nR = 1'b0;
    @(negedge clk);
    chk("abort mode", mode, 0);
    chk("abort outData", outData, 0);
    chk("abort flags", {loadData, loadKey, doneData, doneKey}, 0);
    nR = 1'b1;
    @(negedge clk);
    chk("abort stays IDLE", mode, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
